// File: rtl/cache_bus_arbiter_if.sv
// Bus bundle between the two L1 caches, the cache bus arbiter and the memory-side AXI bridge.
// The slave modport is the arbiter's view; the master modport is the caches-plus-memory side.
interface cache_bus_arbiter_if #(
   parameter int ADDR_W = 64,
   parameter int DATA_W = 64
);
   logic              io_ic_r_valid;
   logic [ADDR_W-1:0] io_ic_r_bits_raddr;
   logic [DATA_W-1:0] io_ic_r_bits_rdata;
   logic              io_ic_r_bits_rlast;
   logic              io_ic_r_ready;

   logic              io_dc_r_valid;
   logic [ADDR_W-1:0] io_dc_r_bits_raddr;
   logic [DATA_W-1:0] io_dc_r_bits_rdata;
   logic              io_dc_r_bits_rlast;
   logic              io_dc_r_ready;

   logic              io_dc_w_valid;
   logic [ADDR_W-1:0] io_dc_w_bits_waddr;
   logic [DATA_W-1:0] io_dc_w_bits_wdata;
   logic              io_dc_w_bits_wlast;
   logic              io_dc_w_ready;
   logic              io_dc_b_valid;
   logic              io_dc_b_ready;

   logic              io_mem_r_valid;
   logic [ADDR_W-1:0] io_mem_r_bits_raddr;
   logic [DATA_W-1:0] io_mem_r_bits_rdata;
   logic              io_mem_r_bits_rlast;
   logic              io_mem_r_ready;

   logic              io_mem_w_valid;
   logic [ADDR_W-1:0] io_mem_w_bits_waddr;
   logic [DATA_W-1:0] io_mem_w_bits_wdata;
   logic              io_mem_w_bits_wlast;
   logic              io_mem_w_ready;
   logic              io_mem_b_valid;
   logic              io_mem_b_ready;

   logic              io_wr_busy;

   modport slave (
      input  io_ic_r_valid, io_ic_r_bits_raddr,
      output io_ic_r_bits_rdata, io_ic_r_bits_rlast, io_ic_r_ready,
      input  io_dc_r_valid, io_dc_r_bits_raddr,
      output io_dc_r_bits_rdata, io_dc_r_bits_rlast, io_dc_r_ready,
      input  io_dc_w_valid, io_dc_w_bits_waddr, io_dc_w_bits_wdata, io_dc_w_bits_wlast,
      output io_dc_w_ready, io_dc_b_valid,
      input  io_dc_b_ready,
      output io_mem_r_valid, io_mem_r_bits_raddr,
      input  io_mem_r_bits_rdata, io_mem_r_bits_rlast, io_mem_r_ready,
      output io_mem_w_valid, io_mem_w_bits_waddr, io_mem_w_bits_wdata, io_mem_w_bits_wlast,
      input  io_mem_w_ready, io_mem_b_valid,
      output io_mem_b_ready,
      output io_wr_busy
   );

   modport master (
      output io_ic_r_valid, io_ic_r_bits_raddr,
      input  io_ic_r_bits_rdata, io_ic_r_bits_rlast, io_ic_r_ready,
      output io_dc_r_valid, io_dc_r_bits_raddr,
      input  io_dc_r_bits_rdata, io_dc_r_bits_rlast, io_dc_r_ready,
      output io_dc_w_valid, io_dc_w_bits_waddr, io_dc_w_bits_wdata, io_dc_w_bits_wlast,
      input  io_dc_w_ready, io_dc_b_valid,
      output io_dc_b_ready,
      input  io_mem_r_valid, io_mem_r_bits_raddr,
      output io_mem_r_bits_rdata, io_mem_r_bits_rlast, io_mem_r_ready,
      input  io_mem_w_valid, io_mem_w_bits_waddr, io_mem_w_bits_wdata, io_mem_w_bits_wlast,
      output io_mem_w_ready, io_mem_b_valid,
      input  io_mem_b_ready,
      input  io_wr_busy
   );
endinterface

// File: rtl/cache_bus_arbiter.sv
// Shares the memory-side cache bus between ICache and DCache: per-burst read arbitration,
// DCache write-back forwarding. Define CACHE_ARB_RR_EN for round-robin instead of DCache priority.
module cache_bus_arbiter #(
   parameter int ADDR_W = 64,
   parameter int DATA_W = 64
) (
   input  logic                 clock,
   input  logic                 reset,
   cache_bus_arbiter_if.slave   bus
);

   typedef enum logic [1:0] {R_IDLE, R_IC, R_DC} read_state_t;
   typedef enum logic {GRANT_IC, GRANT_DC} grant_t;

`ifdef CACHE_ARB_RR_EN
   localparam bit RR_EN = 1'b1;
`else
   localparam bit RR_EN = 1'b0;
`endif

   read_state_t state;
   grant_t      last_grant;
   logic        wr_busy;
   logic        r_last_fire;
   logic        w_fire;
   logic        b_fire;

   assign r_last_fire = bus.io_mem_r_ready & bus.io_mem_r_bits_rlast;
   assign w_fire      = bus.io_mem_w_valid & bus.io_mem_w_ready;
   assign b_fire      = bus.io_mem_b_valid & bus.io_dc_b_ready;

   // A grant is only issued from R_IDLE, so the rlast cycle always leaves one idle cycle
   // before the next burst; a granted requester dropping r_valid early does not release the bus.
   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= R_IDLE;
         last_grant <= GRANT_IC;
         wr_busy    <= 1'b0;
      end else begin
         case (state)
            R_IDLE: begin
               if (bus.io_dc_r_valid && bus.io_ic_r_valid)
                  state <= (RR_EN && last_grant == GRANT_DC) ? R_IC : R_DC;
               else if (bus.io_dc_r_valid)
                  state <= R_DC;
               else if (bus.io_ic_r_valid)
                  state <= R_IC;
            end
            R_IC: begin
               if (r_last_fire) begin
                  state      <= R_IDLE;
                  last_grant <= GRANT_IC;
               end
            end
            R_DC: begin
               if (r_last_fire) begin
                  state      <= R_IDLE;
                  last_grant <= GRANT_DC;
               end
            end
            default: state <= R_IDLE;
         endcase

         if (b_fire)
            wr_busy <= 1'b0;
         else if (w_fire)
            wr_busy <= 1'b1;
      end
   end

   // Read routing follows the registered grant; the non-granted cache sees an all-zero channel.
   always_comb begin
      bus.io_mem_r_valid      = 1'b0;
      bus.io_mem_r_bits_raddr = {ADDR_W{1'b0}};
      bus.io_ic_r_bits_rdata  = {DATA_W{1'b0}};
      bus.io_ic_r_bits_rlast  = 1'b0;
      bus.io_ic_r_ready       = 1'b0;
      bus.io_dc_r_bits_rdata  = {DATA_W{1'b0}};
      bus.io_dc_r_bits_rlast  = 1'b0;
      bus.io_dc_r_ready       = 1'b0;
      case (state)
         R_IC: begin
            bus.io_mem_r_valid      = bus.io_ic_r_valid;
            bus.io_mem_r_bits_raddr = bus.io_ic_r_bits_raddr;
            bus.io_ic_r_bits_rdata  = bus.io_mem_r_bits_rdata;
            bus.io_ic_r_bits_rlast  = bus.io_mem_r_bits_rlast;
            bus.io_ic_r_ready       = bus.io_mem_r_ready;
         end
         R_DC: begin
            bus.io_mem_r_valid      = bus.io_dc_r_valid;
            bus.io_mem_r_bits_raddr = bus.io_dc_r_bits_raddr;
            bus.io_dc_r_bits_rdata  = bus.io_mem_r_bits_rdata;
            bus.io_dc_r_bits_rlast  = bus.io_mem_r_bits_rlast;
            bus.io_dc_r_ready       = bus.io_mem_r_ready;
         end
         default: ;
      endcase
   end

   assign bus.io_mem_w_valid      = bus.io_dc_w_valid;
   assign bus.io_mem_w_bits_waddr = bus.io_dc_w_bits_waddr;
   assign bus.io_mem_w_bits_wdata = bus.io_dc_w_bits_wdata;
   assign bus.io_mem_w_bits_wlast = bus.io_dc_w_bits_wlast;
   assign bus.io_dc_w_ready       = bus.io_mem_w_ready;
   assign bus.io_dc_b_valid       = bus.io_mem_b_valid;
   assign bus.io_mem_b_ready      = bus.io_dc_b_ready;
   assign bus.io_wr_busy          = wr_busy;

endmodule

// File: tb/tb_cache_bus_arbiter.sv
// Directed bench for cache_bus_arbiter: single reads, contention, write-back overlap,
// reset mid-burst and memory stalls, with hand-computed expectations.
module tb_cache_bus_arbiter;

   logic clock;
   logic reset;
   int   nAssert;
   int   nFail;

   cache_bus_arbiter_if #(.ADDR_W(64), .DATA_W(64)) bus ();

   cache_bus_arbiter #(.ADDR_W(64), .DATA_W(64)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic applyStimulus(input logic ready, input logic [63:0] data, input logic last);
      bus.io_mem_r_ready      = ready;
      bus.io_mem_r_bits_rdata = data;
      bus.io_mem_r_bits_rlast = last;
   endtask

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      nAssert++;
      assert (observed === expected)
      else begin
         nFail++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   initial begin
      nAssert = 0;
      nFail   = 0;
      reset   = 1'b1;
      bus.io_ic_r_valid      = 1'b0;
      bus.io_ic_r_bits_raddr = '0;
      bus.io_dc_r_valid      = 1'b0;
      bus.io_dc_r_bits_raddr = '0;
      bus.io_dc_w_valid      = 1'b0;
      bus.io_dc_w_bits_waddr = '0;
      bus.io_dc_w_bits_wdata = '0;
      bus.io_dc_w_bits_wlast = 1'b0;
      bus.io_dc_b_ready      = 1'b0;
      bus.io_mem_w_ready     = 1'b0;
      bus.io_mem_b_valid     = 1'b0;
      applyStimulus(1'b0, 64'h0, 1'b0);
      tick();
      tick();
      checkOutput("rst_mem_r_valid", {63'b0, bus.io_mem_r_valid}, 64'd0);
      checkOutput("rst_ic_r_ready", {63'b0, bus.io_ic_r_ready}, 64'd0);
      checkOutput("rst_dc_r_ready", {63'b0, bus.io_dc_r_ready}, 64'd0);
      checkOutput("rst_wr_busy", {63'b0, bus.io_wr_busy}, 64'd0);
      reset = 1'b0;

      // T1: ICache alone, two beats
      tick();
      bus.io_ic_r_valid      = 1'b1;
      bus.io_ic_r_bits_raddr = 64'h8000_0000;
      settle();
      checkOutput("t1_no_grant_yet", {63'b0, bus.io_mem_r_valid}, 64'd0);
      tick();
      checkOutput("t1_mem_r_valid", {63'b0, bus.io_mem_r_valid}, 64'd1);
      checkOutput("t1_raddr", bus.io_mem_r_bits_raddr, 64'h8000_0000);
      applyStimulus(1'b1, 64'h11, 1'b0);
      settle();
      checkOutput("t1_ic_ready_b0", {63'b0, bus.io_ic_r_ready}, 64'd1);
      checkOutput("t1_ic_data_b0", bus.io_ic_r_bits_rdata, 64'h11);
      checkOutput("t1_dc_ready_b0", {63'b0, bus.io_dc_r_ready}, 64'd0);
      tick();
      applyStimulus(1'b1, 64'h22, 1'b1);
      settle();
      checkOutput("t1_ic_data_b1", bus.io_ic_r_bits_rdata, 64'h22);
      checkOutput("t1_ic_rlast_b1", {63'b0, bus.io_ic_r_bits_rlast}, 64'd1);
      checkOutput("t1_dc_rlast_b1", {63'b0, bus.io_dc_r_bits_rlast}, 64'd0);
      tick();
      bus.io_ic_r_valid = 1'b0;
      applyStimulus(1'b0, 64'h0, 1'b0);
      settle();
      checkOutput("t1_idle_after", {63'b0, bus.io_mem_r_valid}, 64'd0);

      // T2: simultaneous requests, DCache first, ICache after one idle cycle
      tick();
      bus.io_ic_r_valid      = 1'b1;
      bus.io_ic_r_bits_raddr = 64'h1000;
      bus.io_dc_r_valid      = 1'b1;
      bus.io_dc_r_bits_raddr = 64'h2000;
      tick();
      checkOutput("t2_first_raddr", bus.io_mem_r_bits_raddr, 64'h2000);
      applyStimulus(1'b1, 64'h33, 1'b1);
      settle();
      checkOutput("t2_dc_ready", {63'b0, bus.io_dc_r_ready}, 64'd1);
      checkOutput("t2_dc_data", bus.io_dc_r_bits_rdata, 64'h33);
      checkOutput("t2_ic_ready", {63'b0, bus.io_ic_r_ready}, 64'd0);
      checkOutput("t2_ic_data", bus.io_ic_r_bits_rdata, 64'h0);
      tick();
      bus.io_dc_r_valid = 1'b0;
      applyStimulus(1'b0, 64'h0, 1'b0);
      settle();
      checkOutput("t2_idle_gap", {63'b0, bus.io_mem_r_valid}, 64'd0);
      tick();
      checkOutput("t2_second_raddr", bus.io_mem_r_bits_raddr, 64'h1000);
      checkOutput("t2_second_valid", {63'b0, bus.io_mem_r_valid}, 64'd1);
      applyStimulus(1'b1, 64'h34, 1'b1);
      tick();
      bus.io_ic_r_valid = 1'b0;
      applyStimulus(1'b0, 64'h0, 1'b0);

      // T3: both keep requesting; DCache re-requests straight after rlast
      tick();
      bus.io_ic_r_valid = 1'b1;
      bus.io_dc_r_valid = 1'b1;
      tick();
      checkOutput("t3_burst0_raddr", bus.io_mem_r_bits_raddr, 64'h2000);
      applyStimulus(1'b1, 64'h35, 1'b1);
      tick();
      applyStimulus(1'b0, 64'h0, 1'b0);
      tick();
`ifdef CACHE_ARB_RR_EN
      checkOutput("t3_burst1_raddr", bus.io_mem_r_bits_raddr, 64'h1000);
`else
      checkOutput("t3_burst1_raddr", bus.io_mem_r_bits_raddr, 64'h2000);
      checkOutput("t3_ic_waiting", {63'b0, bus.io_ic_r_ready}, 64'd0);
`endif
      applyStimulus(1'b1, 64'h36, 1'b1);
      tick();
      bus.io_ic_r_valid = 1'b0;
      bus.io_dc_r_valid = 1'b0;
      applyStimulus(1'b0, 64'h0, 1'b0);
      tick();

      // T4: write-back concurrent with an ICache read
      bus.io_ic_r_valid      = 1'b1;
      bus.io_ic_r_bits_raddr = 64'h3000;
      bus.io_dc_w_valid      = 1'b1;
      bus.io_dc_w_bits_waddr = 64'h8000_1000;
      bus.io_dc_w_bits_wdata = 64'hA;
      bus.io_dc_w_bits_wlast = 1'b0;
      bus.io_mem_w_ready     = 1'b1;
      settle();
      checkOutput("t4_w_valid_fwd", {63'b0, bus.io_mem_w_valid}, 64'd1);
      checkOutput("t4_waddr_fwd", bus.io_mem_w_bits_waddr, 64'h8000_1000);
      checkOutput("t4_wdata0_fwd", bus.io_mem_w_bits_wdata, 64'hA);
      checkOutput("t4_w_ready_fwd", {63'b0, bus.io_dc_w_ready}, 64'd1);
      checkOutput("t4_busy_before", {63'b0, bus.io_wr_busy}, 64'd0);
      tick();
      checkOutput("t4_busy_set", {63'b0, bus.io_wr_busy}, 64'd1);
      bus.io_dc_w_bits_wdata = 64'hB;
      bus.io_dc_w_bits_wlast = 1'b1;
      applyStimulus(1'b1, 64'h44, 1'b0);
      settle();
      checkOutput("t4_wdata1_fwd", bus.io_mem_w_bits_wdata, 64'hB);
      checkOutput("t4_wlast_fwd", {63'b0, bus.io_mem_w_bits_wlast}, 64'd1);
      checkOutput("t4_ic_data_b0", bus.io_ic_r_bits_rdata, 64'h44);
      tick();
      bus.io_dc_w_valid  = 1'b0;
      bus.io_dc_w_bits_wlast = 1'b0;
      bus.io_mem_w_ready = 1'b0;
      bus.io_mem_b_valid = 1'b1;
      bus.io_dc_b_ready  = 1'b1;
      applyStimulus(1'b1, 64'h55, 1'b1);
      settle();
      checkOutput("t4_b_valid_fwd", {63'b0, bus.io_dc_b_valid}, 64'd1);
      checkOutput("t4_b_ready_fwd", {63'b0, bus.io_mem_b_ready}, 64'd1);
      checkOutput("t4_busy_held", {63'b0, bus.io_wr_busy}, 64'd1);
      checkOutput("t4_ic_rlast", {63'b0, bus.io_ic_r_bits_rlast}, 64'd1);
      tick();
      bus.io_mem_b_valid = 1'b0;
      bus.io_dc_b_ready  = 1'b0;
      bus.io_ic_r_valid  = 1'b0;
      applyStimulus(1'b0, 64'h0, 1'b0);
      settle();
      checkOutput("t4_busy_clear", {63'b0, bus.io_wr_busy}, 64'd0);
      checkOutput("t4_read_done", {63'b0, bus.io_mem_r_valid}, 64'd0);

      // T5: reset lands during the first beat of a DCache read with a write outstanding
      tick();
      bus.io_dc_r_valid      = 1'b1;
      bus.io_dc_r_bits_raddr = 64'h4000;
      bus.io_dc_w_valid      = 1'b1;
      bus.io_dc_w_bits_wlast = 1'b1;
      bus.io_mem_w_ready     = 1'b1;
      tick();
      bus.io_dc_w_valid      = 1'b0;
      bus.io_dc_w_bits_wlast = 1'b0;
      bus.io_mem_w_ready     = 1'b0;
      applyStimulus(1'b1, 64'h66, 1'b0);
      settle();
      checkOutput("t5_busy_pre", {63'b0, bus.io_wr_busy}, 64'd1);
      checkOutput("t5_dc_ready_pre", {63'b0, bus.io_dc_r_ready}, 64'd1);
      reset = 1'b1;
      tick();
      checkOutput("t5_mem_r_valid", {63'b0, bus.io_mem_r_valid}, 64'd0);
      checkOutput("t5_dc_ready", {63'b0, bus.io_dc_r_ready}, 64'd0);
      checkOutput("t5_ic_ready", {63'b0, bus.io_ic_r_ready}, 64'd0);
      checkOutput("t5_wr_busy", {63'b0, bus.io_wr_busy}, 64'd0);
      reset = 1'b0;
      bus.io_dc_r_valid = 1'b0;
      applyStimulus(1'b0, 64'h0, 1'b0);
      tick();
      checkOutput("t5_stays_idle", {63'b0, bus.io_mem_r_valid}, 64'd0);

      // T6: memory stalls five cycles mid-burst while ICache waits
      bus.io_dc_r_valid      = 1'b1;
      bus.io_dc_r_bits_raddr = 64'h5000;
      bus.io_ic_r_valid      = 1'b1;
      bus.io_ic_r_bits_raddr = 64'h6000;
      tick();
      applyStimulus(1'b1, 64'h77, 1'b0);
      settle();
      checkOutput("t6_beat0_data", bus.io_dc_r_bits_rdata, 64'h77);
      tick();
      applyStimulus(1'b0, 64'h0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         settle();
         checkOutput("t6_stall_raddr", bus.io_mem_r_bits_raddr, 64'h5000);
         checkOutput("t6_stall_ic_ready", {63'b0, bus.io_ic_r_ready}, 64'd0);
         tick();
      end
      applyStimulus(1'b1, 64'h88, 1'b1);
      settle();
      checkOutput("t6_dc_rlast", {63'b0, bus.io_dc_r_bits_rlast}, 64'd1);
      checkOutput("t6_dc_data", bus.io_dc_r_bits_rdata, 64'h88);
      tick();
      bus.io_dc_r_valid = 1'b0;
      applyStimulus(1'b0, 64'h0, 1'b0);
      settle();
      checkOutput("t6_idle_gap", {63'b0, bus.io_mem_r_valid}, 64'd0);
      tick();
      checkOutput("t6_switch_raddr", bus.io_mem_r_bits_raddr, 64'h6000);
      applyStimulus(1'b1, 64'h99, 1'b1);
      settle();
      checkOutput("t6_ic_ready", {63'b0, bus.io_ic_r_ready}, 64'd1);
      tick();
      bus.io_ic_r_valid = 1'b0;
      applyStimulus(1'b0, 64'h0, 1'b0);
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
      $finish;
   end

endmodule
